cbus_rr_arbiter: RTL

Parametrised N-to-1 arbiter on the cache bus (cbus), between the core's memory clients (instruction fetch, data access, page-table walker, DMA-style masters) and the single downstream cbus port (MMU / memory). Supports fixed-priority or round-robin selection. Holds the grant for a whole burst until the final response beat. Exposes the current grant for debug and performance counters. Optionally forwards the winning request in the arbitration cycle to remove the one-cycle issue latency.

---
 rtl/cbus_rr_arbiter_pkg.sv | 38 +++
 rtl/cbus_rr_picker.sv | 41 ++++
 rtl/cbus_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types and arbiter constants.
// Used by cbus_rr_picker and cbus_rr_arbiter.
package cbus_rr_arbiter_pkg;

  localparam int unsigned CBUS_ARB_MAX_INPUTS = 16;
  localparam int unsigned CBUS_ADDR_W         = 32;
  localparam int unsigned CBUS_DATA_W         = 32;

  // Request from a client toward memory. The owner must hold every field
  // stable from the grant until its final response beat.
  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] wdata;
    logic [3:0]             be;
  } cbus_req_t;

  // Response beat from memory. ready && last ends the transaction.
  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Rotating-priority successor of a winner. The wrap is explicit so that
  // requester counts that are not a power of two are handled correctly.
  function automatic int unsigned rr_next(input int unsigned winner,
                                          input int unsigned n);
    return (winner + 32'd1 >= n) ? 32'd0 : winner + 32'd1;
  endfunction

endpackage

// File: rtl/cbus_rr_picker.sv
// Combinational winner selection for the cbus arbiter.
// rr_en_i=1: search starts at ptr_i and wraps modulo NUM_INPUTS.
// rr_en_i=0: lowest valid index wins and ptr_i is ignored.
module cbus_rr_picker
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] valid_i,
  input  logic [IDX_W-1:0]      ptr_i,
  input  logic                  rr_en_i,
  output logic                  any_valid_o,
  output logic [IDX_W-1:0]      winner_o
);

  int unsigned start;
  int unsigned rank;
  int unsigned best;

  // Each input gets a rank equal to its distance from the search start; the
  // valid input with the smallest rank wins.
  always_comb begin
    any_valid_o = |valid_i;
    winner_o    = '0;
    start       = rr_en_i ? 32'(ptr_i) : 32'd0;
    if (start >= NUM_INPUTS) begin
      start = 32'd0;
    end
    best = NUM_INPUTS;
    rank = 32'd0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      rank = (i >= start) ? (i - start) : (i + NUM_INPUTS - start);
      if (valid_i[i] && (rank < best)) begin
        best     = rank;
        winner_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 cbus arbiter, fixed or round-robin priority, burst-locked grant.
// Optional feature macro: CBUS_ARB_FASTPATH_EN forwards the winning request
// combinationally in the arbitration cycle (zero issue latency).
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  cbus_req_t            ireqs  [NUM_INPUTS],
  output cbus_resp_t           iresps [NUM_INPUTS],
  output cbus_req_t            oreq,
  input  cbus_resp_t           oresp,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_index
);

`ifdef CBUS_ARB_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic [NUM_INPUTS-1:0] req_valid;
  logic                  any_valid;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      ptr_after_win;
  logic                  last_beat;

  logic                  route_en;
  logic [IDX_W-1:0]      route_idx;

  // Gather the valid bits of every requester for the picker.
  always_comb begin
    req_valid = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
    end
  end

  cbus_rr_picker #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .valid_i     (req_valid),
    .ptr_i       (ptr_q),
    .rr_en_i     (ROUND_ROBIN),
    .any_valid_o (any_valid),
    .winner_o    (winner)
  );

  assign last_beat     = oresp.ready & oresp.last;
  assign ptr_after_win = IDX_W'(rr_next(32'(winner), NUM_INPUTS));

  // State, owner index and rotation pointer; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: arbitrate only in IDLE; hold the owner until its last beat.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          idx_d = winner;
          if (ROUND_ROBIN) begin
            ptr_d = ptr_after_win;
          end
          // A forwarded single-beat zero-wait transaction already finished
          // in the arbitration cycle, so there is nothing left to own.
          if (FASTPATH && last_beat) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_BUSY;
          end
        end
      end
      ARB_BUSY: begin
        if (last_beat) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Select which requester (if any) is connected to the downstream port.
  always_comb begin
    route_en  = 1'b0;
    route_idx = idx_q;
    if (state_q == ARB_BUSY) begin
      route_en  = 1'b1;
      route_idx = idx_q;
    end else if (FASTPATH && any_valid) begin
      route_en  = 1'b1;
      route_idx = winner;
    end
  end

  // Request/response muxes: only the routed requester sees traffic.
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
      if (route_en && (IDX_W'(i) == route_idx)) begin
        oreq      = ireqs[i];
        iresps[i] = oresp;
      end
    end
  end

  assign grant_valid = (state_q == ARB_BUSY);
  assign grant_index = grant_valid ? idx_q : '0;

endmodule
